pc_attack_ctrl: RTL
===================

// Module: pc_attack_ctrl
// PURPOSE
//  Sequences the computer's shot during the game FSM's PC_TURN state.
//  - Draws a pseudo-random cell; retries if that cell was already attacked.
//  - Reads the player board, marks the cell HIT or MISS, then pulses pc_move so the FSM returns to PLAYER_TURN.
//  - Sits between the game FSM, the player-board RAM and the VGA update logic.
// PARAMETERS
//  ROWS       5      board rows (1..8)
//  COLS       5      board columns (1..8)
//  LFSR_SEED  8'hA5  non-zero LFSR reset value
//  MAX_TRIES  16     random draws before switching to a linear scan
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous, active-low reset
//  pc_turn_State in   1  high while the game FSM is in PC_TURN
//  brd_rd_en     out  1  board read strobe, one cycle
//  brd_rd_valid  in   1  read data valid; arrives >=1 cycle after brd_rd_en
//  brd_rd_data   in   2  cell code: 00 water, 01 ship, 10 miss, 11 hit
//  brd_wr_en     out  1  board write strobe, one cycle
//  brd_wr_data   out  2  code written (10 or 11)
//  brd_row       out  3  target row, shared by read and write
//  brd_col       out  3  target column
//  hit_pulse     out  1  one cycle; shot struck a ship cell
//  pc_move       out  1  one cycle; PC turn finished
//  board_full    out  1  sticky; no unattacked cell remained
// BEHAVIOUR
//  Reset: state IDLE, LFSR=LFSR_SEED, all outputs 0, try count 0.
//  LFSR
//   - 8-bit Fibonacci, taps 8,6,5,4; shifts every clk in every state.
//   - Free-running, so draws depend on player timing.
//   - Candidate: row=lfsr[2:0], col=lfsr[5:3].
//  FSM
//   - IDLE: on pc_turn_State=1 -> PICK; tries=0.
//   - PICK: if tries<MAX_TRIES, latch the LFSR candidate and tries++.
//     Else take the scan pointer (row-major from 0,0, advanced per failure).
//     - Out-of-range candidate (row>=ROWS or col>=COLS): counts as a try, stay in PICK.
//     - Scan pointer past the last cell: set board_full -> DONE with no write.
//     - Otherwise -> READ.
//   - READ: brd_rd_en=1 for one cycle -> WAIT.
//   - WAIT: hold row/col until brd_rd_valid -> EVAL.
//   - EVAL: code 1x (already attacked) -> PICK.
//     Code 00 -> WRITE, wr_data=10. Code 01 -> WRITE, wr_data=11.
//   - WRITE: brd_wr_en=1 for one cycle. hit_pulse=1 in the same cycle if the code is 11 -> DONE.
//   - DONE: pc_move=1 for one cycle -> EXIT.
//   - EXIT: wait for pc_turn_State=0 -> IDLE. No second pc_move is issued while PC_TURN lingers.
//  Latency: best case PICK -> pc_move = 5 cycles with 1-cycle RAM latency.
//  Abort: pc_turn_State=0 in PICK/READ/WAIT/EVAL -> IDLE next cycle.
//   - No write occurs; a late brd_rd_valid is ignored.
//   - Once in WRITE, the write and pc_move still complete.
//  Row/col remain stable from READ through WRITE.
//  board_full clears only on reset.
//  Async reset mid-operation: immediate return to reset values; no partial write is held.
// STRUCTURE
//  battleship_pkg:
//   - cell_t enum (WATER, SHIP, MISS, HIT)
//   - BOARD_ROWS/BOARD_COLS constants
//   - pc_atk_state_t enum
//  Sub-module lfsr8 (clk, rst, seed, q[7:0]); reused by the setup randomiser.
// TESTING
//  1 Reset held with pc_turn_State=1 -> all outputs 0, no rd_en. Release -> first rd_en within 3 cycles.
//  2 Board all water, 1-cycle RAM -> one rd_en, one wr_en with data 10, pc_move 5 cycles after PICK, hit_pulse=0.
//  3 Model returns 01 at the drawn cell -> wr_data=11, hit_pulse and wr_en coincide, pc_move next cycle.
//  4 All cells but (4,4) preset to 10 -> after 16 tries the scan reaches (4,4); exactly one write there.
//  5 All 25 cells attacked -> board_full=1, pc_move=1, brd_wr_en never asserted.
//  6 pc_turn_State dropped during WAIT (RAM latency 4) -> IDLE, no wr_en, no pc_move.
//    Holding PC_TURN after DONE -> only one pc_move.

Source files
------------

// File: rtl/battleship_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | battleship_pkg                                                     |
// | Shared board cell codes, board size and PC attack FSM state type.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package battleship_pkg;

    typedef enum logic [1:0] {
        WATER = 2'b00,
        SHIP  = 2'b01,
        MISS  = 2'b10,
        HIT   = 2'b11
    } cell_t;

    localparam int         BOARD_ROWS        = 5;
    localparam int         BOARD_COLS        = 5;
    localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;
    localparam int         PC_ATK_MAX_TRIES  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK  = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EVAL  = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6,
        ST_EXIT  = 3'd7
    } pc_atk_state_t;

    // Codes 10 and 11 both have bit 1 set: the cell was already shot at.
    function automatic logic cell_attacked(input logic [1:0] code);
        return code[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_attack_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_attack_ctrl_if                                                  |
// | Player-board RAM access bus: shared row/col, read and write ports. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pc_attack_ctrl_if;
    logic       brd_rd_en;
    logic       brd_rd_valid;
    logic [1:0] brd_rd_data;
    logic       brd_wr_en;
    logic [1:0] brd_wr_data;
    logic [2:0] brd_row;
    logic [2:0] brd_col;

    modport master (
        output brd_rd_en, brd_wr_en, brd_wr_data, brd_row, brd_col,
        input  brd_rd_valid, brd_rd_data
    );

    modport slave (
        input  brd_rd_en, brd_wr_en, brd_wr_data, brd_row, brd_col,
        output brd_rd_valid, brd_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr8                                                              |
// | Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4, loadable seed.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lfsr8 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [7:0] seed,
    output logic      [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= seed;
        end else begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pc_attack_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_attack_ctrl                                                     |
// | Picks an unattacked cell, reads it, marks HIT/MISS, ends PC turn.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_attack_ctrl
    import battleship_pkg::*;
#(
    parameter int         ROWS      = BOARD_ROWS,
    parameter int         COLS      = BOARD_COLS,
    parameter logic [7:0] LFSR_SEED = LFSR_DEFAULT_SEED,
    parameter int         MAX_TRIES = PC_ATK_MAX_TRIES
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             pc_turn_State,
    pc_attack_ctrl_if.master      bif,
    output logic                  hit_pulse,
    output logic                  pc_move,
    output logic                  board_full
);

    localparam int                 c_TRY_W     = $clog2(MAX_TRIES + 1);
    localparam logic [c_TRY_W-1:0] c_MAX_TRIES = c_TRY_W'(MAX_TRIES);
    localparam logic [3:0]         c_ROWS      = 4'(ROWS);
    localparam logic [3:0]         c_COLS      = 4'(COLS);
    localparam logic [3:0]         c_LAST_ROW  = 4'(ROWS - 1);
    localparam logic [3:0]         c_LAST_COL  = 4'(COLS - 1);

    pc_atk_state_t      r_state, w_state_nxt;
    logic [2:0]         r_row, w_row_nxt;
    logic [2:0]         r_col, w_col_nxt;
    logic [c_TRY_W-1:0] r_tries, w_tries_nxt;
    logic [2:0]         r_scan_row, w_scan_row_nxt;
    logic [2:0]         r_scan_col, w_scan_col_nxt;
    logic               r_scan_done, w_scan_done_nxt;
    logic [1:0]         r_cell, w_cell_nxt;
    logic [1:0]         r_wr_data, w_wr_data_nxt;
    logic               r_board_full, w_full_nxt;

    logic               w_rd_en, w_wr_en, w_hit, w_move;
    logic [7:0]         w_lfsr;
    logic               w_cand_ok;
    logic               w_unused_lfsr;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (w_lfsr)
    );

    // Only six LFSR bits form a candidate; the top two just feed the shift.
    assign w_unused_lfsr = ^w_lfsr[7:6];
    assign w_cand_ok     = ({1'b0, w_lfsr[2:0]} < c_ROWS) &&
                           ({1'b0, w_lfsr[5:3]} < c_COLS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_tries      <= '0;
            r_scan_row   <= '0;
            r_scan_col   <= '0;
            r_scan_done  <= 1'b0;
            r_cell       <= '0;
            r_wr_data    <= '0;
            r_board_full <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_tries      <= w_tries_nxt;
            r_scan_row   <= w_scan_row_nxt;
            r_scan_col   <= w_scan_col_nxt;
            r_scan_done  <= w_scan_done_nxt;
            r_cell       <= w_cell_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_board_full <= w_full_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_tries_nxt     = r_tries;
        w_scan_row_nxt  = r_scan_row;
        w_scan_col_nxt  = r_scan_col;
        w_scan_done_nxt = r_scan_done;
        w_cell_nxt      = r_cell;
        w_wr_data_nxt   = r_wr_data;
        w_full_nxt      = r_board_full;
        w_rd_en         = 1'b0;
        w_wr_en         = 1'b0;
        w_hit           = 1'b0;
        w_move          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (pc_turn_State) begin
                    w_state_nxt     = ST_PICK;
                    w_tries_nxt     = '0;
                    w_scan_row_nxt  = '0;
                    w_scan_col_nxt  = '0;
                    w_scan_done_nxt = 1'b0;
                end
            end
            ST_PICK: begin
                if (!pc_turn_State) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_tries < c_MAX_TRIES) begin
                    w_tries_nxt = r_tries + c_TRY_W'(1);
                    if (w_cand_ok) begin
                        w_row_nxt   = w_lfsr[2:0];
                        w_col_nxt   = w_lfsr[5:3];
                        w_state_nxt = ST_READ;
                    end
                end else if (r_scan_done) begin
                    w_full_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    // Post-increment: the pointer moves past each cell as it is taken.
                    w_row_nxt   = r_scan_row;
                    w_col_nxt   = r_scan_col;
                    w_state_nxt = ST_READ;
                    if ({1'b0, r_scan_col} == c_LAST_COL) begin
                        w_scan_col_nxt = '0;
                        if ({1'b0, r_scan_row} == c_LAST_ROW) begin
                            w_scan_done_nxt = 1'b1;
                        end else begin
                            w_scan_row_nxt = r_scan_row + 3'd1;
                        end
                    end else begin
                        w_scan_col_nxt = r_scan_col + 3'd1;
                    end
                end
            end
            ST_READ: begin
                w_rd_en     = 1'b1;
                w_state_nxt = pc_turn_State ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (!pc_turn_State) begin
                    w_state_nxt = ST_IDLE;
                end else if (bif.brd_rd_valid) begin
                    w_cell_nxt  = bif.brd_rd_data;
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (!pc_turn_State) begin
                    w_state_nxt = ST_IDLE;
                end else if (cell_attacked(r_cell)) begin
                    w_state_nxt = ST_PICK;
                end else begin
                    w_wr_data_nxt = r_cell[0] ? HIT : MISS;
                    w_state_nxt   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_wr_en     = 1'b1;
                w_hit       = (r_wr_data == HIT);
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_move      = 1'b1;
                w_state_nxt = ST_EXIT;
            end
            ST_EXIT: begin
                if (!pc_turn_State) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bif.brd_rd_en   = w_rd_en;
    assign bif.brd_wr_en   = w_wr_en;
    assign bif.brd_wr_data = r_wr_data;
    assign bif.brd_row     = r_row;
    assign bif.brd_col     = r_col;
    assign hit_pulse       = w_hit;
    assign pc_move         = w_move;
    assign board_full      = r_board_full;

endmodule
`default_nettype wire
